// File: rtl/mips_fetch_controller_pkg.sv
// Shared definitions for the MiniMIPS instruction-fetch controller.
// The fetch-state encodings and the default memory geometry live here so that
// the fetch controller and the instruction memory beside it agree on them.
package mips_fetch_controller_pkg;

    localparam int IMEM_DEPTH_DEF = 35;
    localparam int ADDR_W_DEF     = 32;
    localparam int INSTR_W_DEF    = 16;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_controller.sv
// MiniMIPS fetch controller: drives the instruction-memory address, tracks the
// single in-flight read and presents a valid/stall handshake to decode.
// Taken branches squash the sequential fetch (one bubble), fetch stops at the
// end of memory or on an out-of-range target, and accepted instructions are
// counted.
module mips_fetch_controller
    import mips_fetch_controller_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  next_pc_nxt;
    logic [ADDR_W-1:0]  req_pc;
    logic [ADDR_W-1:0]  req_pc_nxt;
    logic               req_valid;
    logic               req_valid_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    logic               in_fetch;
    logic               accept;
    logic               redirect;
    logic               in_range;
    logic               issue;
    logic               at_end;

    // Handshake decode: stall outranks a branch, so a stalled branch is simply
    // re-evaluated once decode accepts it.
    always_comb begin
        in_fetch = (state == FS_FETCH);
        accept   = in_fetch && req_valid && !stall;
        redirect = accept && branch_taken;
        in_range = (next_pc < DEPTH_A);
        issue    = in_fetch && !stall && !redirect && in_range;
        at_end   = in_fetch && !in_range && !redirect && (!req_valid || accept);
    end

    // Next-state and next-datapath values; everything holds unless changed.
    always_comb begin
        state_nxt     = state;
        next_pc_nxt   = next_pc;
        req_pc_nxt    = req_pc;
        req_valid_nxt = req_valid;
        count_nxt     = count;

        case (state)
            FS_IDLE, FS_HALT: begin
                if (start) begin
                    state_nxt     = FS_FETCH;
                    next_pc_nxt   = '0;
                    req_valid_nxt = 1'b0;
                end
            end
            FS_FETCH: begin
                if (accept) begin
                    count_nxt = count + ONE_C;
                end
                if (redirect) begin
                    req_valid_nxt = 1'b0;
                    next_pc_nxt   = branch_target;
                end else if (issue) begin
                    req_pc_nxt    = next_pc;
                    next_pc_nxt   = next_pc + ONE_A;
                    req_valid_nxt = 1'b1;
                end else if (accept) begin
                    req_valid_nxt = 1'b0;
                end
                if (at_end) begin
                    state_nxt = FS_HALT;
                end
            end
            default: begin
                state_nxt     = FS_IDLE;
                req_valid_nxt = 1'b0;
            end
        endcase
    end

    // Address mux: only a fresh issue moves the memory address; otherwise the
    // last request is re-read so a stalled instruction stays stable.
    always_comb begin
        pc          = req_pc;
        if (issue) begin
            pc = next_pc;
        end
        instr_out   = mem_instr;
        instr_valid = req_valid;
        instr_pc    = req_pc;
        halted      = (state == FS_HALT);
        instr_count = count;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FS_IDLE;
            next_pc   <= '0;
            req_pc    <= '0;
            req_valid <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            next_pc   <= next_pc_nxt;
            req_pc    <= req_pc_nxt;
            req_valid <= req_valid_nxt;
            count     <= count_nxt;
        end
    end

endmodule

// File: tb/tb_mips_fetch_controller.sv
// Bench for mips_fetch_controller: directed cycle-level scenarios followed by
// randomized episodes whose accepted-instruction stream is predicted by a
// program-walk model and checked by a scoreboard monitor.
module tb_mips_fetch_controller;

    localparam int DEPTH = 35;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [15:0] mem_instr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] mem [0:DEPTH-1];

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] instr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    bit          sb_on = 1'b0;
    logic [15:0] model_count;
    int          checks = 0;
    int          passed = 0;

    mips_fetch_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .mem_instr     (mem_instr),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word = address + 0x100.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 16'h0100 + 16'(i);
        end
    end

    // One-cycle registered read, like the real instruction memory.
    always @(posedge clk) begin
        mem_instr <= (pc < 32'd35) ? mem[pc[5:0]] : 16'hDEAD;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        $display("[TB] FAIL %s: event occurred with no expectation at %0t", name, $time);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n         = 1'b0;
        start         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic advanceTo(input logic [31:0] addr, input string name);
        int n;
        n = 0;
        while (!(instr_valid && instr_pc == addr) && n < 100) begin
            nextCycle();
            n++;
        end
        checkOutput(name, 64'(instr_valid && instr_pc == addr), 64'd1);
    endtask

    // Scoreboard monitor: every accepted instruction must match the next
    // prediction; pc must never leave the memory.
    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            checkOutput("pc_in_range", 64'(pc < 32'd35), 64'd1);
            if (instr_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    reportFail("unexpected_accept");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("acc_pc", 64'(instr_pc), 64'(e.pc));
                    checkOutput("acc_instr", 64'(instr_out), 64'(e.instr));
                    checkOutput("acc_count", 64'(instr_count), 64'(e.cnt));
                end
            end
        end
    end

    // Random episode: build a branch plan, walk it as a program to predict the
    // accepted stream, then drive it with random stalls and stray inputs.
    task automatic applyStimulus(input int episode);
        bit          take_q[$];
        logic [31:0] tgt_q[$];
        int          addr;
        int          k;
        int          idx;
        int          cyc;
        bit          take;
        int          tgt;
        addr = 0;
        k    = 0;
        idx  = 0;
        cyc  = 0;
        while (addr < DEPTH) begin
            take = (k < 60) && ($urandom_range(0, 4) == 0);
            tgt  = int'($urandom_range(0, DEPTH + 4));
            sb_q.push_back('{pc: 32'(addr), instr: mem[addr], cnt: model_count});
            model_count = model_count + 16'd1;
            take_q.push_back(take);
            tgt_q.push_back(32'(tgt));
            addr = take ? tgt : addr + 1;
            k++;
        end
        $display("[TB] episode %0d: %0d predicted accepts", episode, k);
        sb_on = 1'b1;
        pulseStart();
        while (!halted && cyc < 3000) begin
            stall = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 15) == 0);
            if (instr_valid) begin
                branch_taken  = (idx < take_q.size()) ? take_q[idx] : 1'b0;
                branch_target = (idx < tgt_q.size()) ? tgt_q[idx] : 32'd0;
            end else begin
                branch_taken  = 1'($urandom_range(0, 1));
                branch_target = 32'($urandom_range(0, 40));
            end
            @(negedge clk);
            if (instr_valid && !stall) idx++;
            nextCycle();
            cyc++;
        end
        start        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        checkOutput("ep_halted", 64'(halted), 64'd1);
        checkOutput("ep_drained", 64'(sb_q.size()), 64'd0);
        checkOutput("ep_count", 64'(instr_count), 64'(model_count));
        sb_q.delete();
        nextCycle();
        sb_on = 1'b0;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized episodes, then the summary.
    initial begin
        // Reset state and a full sequential run.
        resetDut();
        #1;
        checkOutput("rst_valid", 64'(instr_valid), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_pc", 64'(pc), 64'd0);
        checkOutput("rst_count", 64'(instr_count), 64'd0);
        pulseStart();
        checkOutput("start_bubble", 64'(instr_valid), 64'd0);
        nextCycle();
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("seq_valid", 64'(instr_valid), 64'd1);
            checkOutput("seq_pc", 64'(instr_pc), 64'(i));
            checkOutput("seq_instr", 64'(instr_out), 64'(16'h0100 + 16'(i)));
            checkOutput("seq_count", 64'(instr_count), 64'(i));
            nextCycle();
        end
        checkOutput("end_halted", 64'(halted), 64'd1);
        checkOutput("end_valid", 64'(instr_valid), 64'd0);
        checkOutput("end_count", 64'(instr_count), 64'd35);

        // Three-cycle stall at address 5, then a branch from 7 to 20.
        resetDut();
        pulseStart();
        advanceTo(32'd5, "reach_5");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_pc", 64'(pc), 64'd5);
            checkOutput("stall_ipc", 64'(instr_pc), 64'd5);
            checkOutput("stall_instr", 64'(instr_out), 64'h105);
            checkOutput("stall_count", 64'(instr_count), 64'd5);
            nextCycle();
        end
        stall = 1'b0;
        nextCycle();
        checkOutput("after_stall_pc", 64'(instr_pc), 64'd6);
        checkOutput("after_stall_count", 64'(instr_count), 64'd6);
        advanceTo(32'd7, "reach_7");
        branch_taken  = 1'b1;
        branch_target = 32'd20;
        nextCycle();
        branch_taken = 1'b0;
        checkOutput("br_bubble", 64'(instr_valid), 64'd0);
        nextCycle();
        checkOutput("br_valid", 64'(instr_valid), 64'd1);
        checkOutput("br_target_pc", 64'(instr_pc), 64'd20);
        checkOutput("br_target_instr", 64'(instr_out), 64'h114);
        checkOutput("br_count", 64'(instr_count), 64'd8);

        // Branch held under stall at address 10: redirect only once unstalled.
        resetDut();
        pulseStart();
        advanceTo(32'd10, "reach_10");
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("sbr_valid", 64'(instr_valid), 64'd1);
            checkOutput("sbr_pc", 64'(instr_pc), 64'd10);
            checkOutput("sbr_count", 64'(instr_count), 64'd10);
            nextCycle();
        end
        stall = 1'b0;
        nextCycle();
        branch_taken = 1'b0;
        checkOutput("sbr_bubble", 64'(instr_valid), 64'd0);
        checkOutput("sbr_bubble_count", 64'(instr_count), 64'd11);
        nextCycle();
        checkOutput("sbr_target_valid", 64'(instr_valid), 64'd1);
        checkOutput("sbr_target_pc", 64'(instr_pc), 64'd3);
        checkOutput("sbr_target_count", 64'(instr_count), 64'd11);

        // Out-of-range target halts; start resumes with the count kept.
        resetDut();
        pulseStart();
        advanceTo(32'd2, "reach_2");
        branch_taken  = 1'b1;
        branch_target = 32'd40;
        nextCycle();
        branch_taken = 1'b0;
        #1;
        checkOutput("oor_bubble", 64'(instr_valid), 64'd0);
        checkOutput("oor_not_halted", 64'(halted), 64'd0);
        checkOutput("oor_bubble_pc", 64'(pc), 64'd2);
        nextCycle();
        checkOutput("oor_halted", 64'(halted), 64'd1);
        checkOutput("oor_pc", 64'(pc), 64'd2);
        checkOutput("oor_count", 64'(instr_count), 64'd3);
        nextCycle();
        checkOutput("oor_halt_held", 64'(halted), 64'd1);
        checkOutput("oor_halt_valid", 64'(instr_valid), 64'd0);
        pulseStart();
        checkOutput("restart_halted", 64'(halted), 64'd0);
        checkOutput("restart_bubble", 64'(instr_valid), 64'd0);
        nextCycle();
        checkOutput("restart_valid", 64'(instr_valid), 64'd1);
        checkOutput("restart_pc", 64'(instr_pc), 64'd0);
        checkOutput("restart_count", 64'(instr_count), 64'd3);

        // Reset in the middle of a run.
        advanceTo(32'd12, "reach_12");
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("mrst_valid", 64'(instr_valid), 64'd0);
        checkOutput("mrst_halted", 64'(halted), 64'd0);
        checkOutput("mrst_pc", 64'(pc), 64'd0);
        checkOutput("mrst_count", 64'(instr_count), 64'd0);
        repeat (3) nextCycle();
        checkOutput("mrst_idle_valid", 64'(instr_valid), 64'd0);
        checkOutput("mrst_idle_pc", 64'(pc), 64'd0);

        // Randomized episodes; the second restarts from HALT.
        resetDut();
        model_count = 16'd0;
        applyStimulus(1);
        applyStimulus(2);
        applyStimulus(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
